reg_file_np: RTL and testbench

Parametrised MIPS general-purpose register file with N combinational read ports, one write port with same-cycle write-through bypass, and architectural HI/LO registers. It adds a handshaked sequential dump engine that streams every register to the testbench or debug monitor, one per accepted beat, without a full-width monitor mux. It sits in ID, fed by WB for writes.

---
 rtl/mips_pkg.sv | 17 +
 rtl/reg_read_port.sv | 27 ++
 rtl/reg_file_np.sv | 139 +++++++++++++
 tb/tb_reg_file_np.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register file defaults, dump engine states,
// and architectural register numbers used by the decode and writeback stages.
package mips_pkg;

   localparam int WIDTH_DEF    = 32;
   localparam int DEPTH_DEF    = 32;
   localparam int ZERO_REG_DEF = 1;

   // Link register written by JAL/JALR, selected by the WB destination logic.
   localparam logic [4:0] REG_RA = 5'd31;

   typedef enum logic {
      DUMP_IDLE = 1'b0,
      DUMP_SCAN = 1'b1
   } dump_state_t;

endpackage

// File: rtl/reg_read_port.sv
// One register file read port: hard-wired zero, same-cycle write bypass,
// otherwise the stored array value.
module reg_read_port #(
   parameter int WIDTH    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic [AW-1:0]    addr,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [WIDTH-1:0] arr_data,
   output logic [WIDTH-1:0] data
);

   // Zero check is last so it overrides a bypass aimed at R0.
   always_comb begin
      data = arr_data;
      if (we && (wa == addr)) begin
         data = wd;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
         data = '0;
      end
   end

endmodule

// File: rtl/reg_file_np.sv
// MIPS GPR file with RD_PORTS combinational read ports, a bypassed write port,
// HI/LO, and a valid/ready dump engine that walks every GPR in index order.
module reg_file_np
   import mips_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int RD_PORTS = 2,
   parameter int ZERO_REG = ZERO_REG_DEF,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [RD_PORTS*AW-1:0]    ra,
   output logic [RD_PORTS*WIDTH-1:0] rd,
   input  logic                      we,
   input  logic [AW-1:0]             wa,
   input  logic [WIDTH-1:0]          wd,
   input  logic                      hi_we,
   input  logic                      lo_we,
   input  logic [WIDTH-1:0]          hi_wd,
   input  logic [WIDTH-1:0]          lo_wd,
   output logic [WIDTH-1:0]          hi,
   output logic [WIDTH-1:0]          lo,
   input  logic                      dump_start,
   input  logic                      dump_ready,
   output logic                      dump_valid,
   output logic [AW-1:0]             dump_idx,
   output logic [WIDTH-1:0]          dump_data,
   output logic                      dump_busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             wr_en;

   dump_state_t      state_q;
   dump_state_t      state_d;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    idx_d;
   logic [WIDTH-1:0] scan_data;

   assign wr_en = we && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wr_en) begin
            regs[wa] <= wd;
         end
         if (hi_we) begin
            hi_q <= hi_wd;
         end
         if (lo_we) begin
            lo_q <= lo_wd;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      reg_read_port #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_port (
         .addr     (ra[k*AW +: AW]),
         .we       (we),
         .wa       (wa),
         .wd       (wd),
         .arr_data (regs[ra[k*AW +: AW]]),
         .data     (rd[k*WIDTH +: WIDTH])
      );
   end

   // The dump path reads through the same bypass rule, so it shows live contents.
   reg_read_port #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_dump_port (
      .addr     (idx_q),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .arr_data (regs[idx_q]),
      .data     (scan_data)
   );

   // Dump handshake: a beat (dump_idx, dump_data) is offered while dump_valid is
   // high and is consumed on a rising edge where dump_valid && dump_ready; the
   // index holds until then, while dump_data may follow writes to that index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         DUMP_IDLE: begin
            if (dump_start) begin
               state_d = DUMP_SCAN;
               idx_d   = '0;
            end
         end
         DUMP_SCAN: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DUMP_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         default: begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      dump_valid = (state_q == DUMP_SCAN);
      dump_busy  = (state_q == DUMP_SCAN);
      dump_idx   = idx_q;
      dump_data  = (state_q == DUMP_SCAN) ? scan_data : '0;
   end

endmodule

// File: tb/tb_reg_file_np.sv
// Directed bench for reg_file_np: a per-cycle reference model of the register
// file and dump stream, plus hand-computed checks and captured dump beats.
module tb_reg_file_np;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int NP = 2;
   localparam int AW = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NP*AW-1:0]  ra = '0;
   logic [NP*W-1:0]   rd;
   logic              we = 1'b0;
   logic [AW-1:0]     wa = '0;
   logic [W-1:0]      wd = '0;
   logic              hi_we = 1'b0;
   logic              lo_we = 1'b0;
   logic [W-1:0]      hi_wd = '0;
   logic [W-1:0]      lo_wd = '0;
   logic [W-1:0]      hi;
   logic [W-1:0]      lo;
   logic              dump_start = 1'b0;
   logic              dump_ready = 1'b0;
   logic              dump_valid;
   logic [AW-1:0]     dump_idx;
   logic [W-1:0]      dump_data;
   logic              dump_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0] m_regs [D];
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   bit           m_active = 1'b0;
   int           m_idx = 0;
   bit           m_ok = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] beat_q[$];

   reg_file_np #(.WIDTH(W), .DEPTH(D), .RD_PORTS(NP), .ZERO_REG(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .ra         (ra),
      .rd         (rd),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .hi_wd      (hi_wd),
      .lo_wd      (lo_wd),
      .hi         (hi),
      .lo         (lo),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_read(input int a);
      if (a == 0) return '0;
      if (we && (int'(wa) == a)) return wd;
      return m_regs[a];
   endfunction

   // Model: architectural effect of each rising edge
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < D; i++) m_regs[i] = '0;
         m_hi = '0;
         m_lo = '0;
         m_active = 1'b0;
         m_idx = 0;
         m_ok = 1'b1;
      end else begin
         if (m_active) begin
            if (dump_ready) begin
               if (m_idx == D - 1) begin
                  m_active = 1'b0;
                  m_idx = 0;
               end else begin
                  m_idx = m_idx + 1;
               end
            end
         end else if (dump_start) begin
            m_active = 1'b1;
            m_idx = 0;
         end
         if (we && wa != 0) m_regs[wa] = wd;
         if (hi_we) m_hi = hi_wd;
         if (lo_we) m_lo = lo_wd;
      end
   end

   // Compare process: every cycle once the model is defined, plus beat capture
   always @(negedge clk) begin
      if (m_ok) begin
         for (int k = 0; k < NP; k++) begin
            chk($sformatf("rd%0d", k), rd[k*W +: W], exp_read(int'(ra[k*AW +: AW])));
         end
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("dump_valid", W'(dump_valid), W'(m_active));
         chk("dump_busy", W'(dump_busy), W'(m_active));
         if (m_active) begin
            chk("dump_idx", W'(dump_idx), W'(m_idx));
            chk("dump_data", dump_data, exp_read(m_idx));
         end
         if (!reset && dump_valid && dump_ready) beat_q.push_back(dump_data);
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ra(input int a0, input int a1);
      ra = {AW'(a1), AW'(a0)};
   endtask

   task automatic wait_idx(input int target, input string name);
      int n = 0;
      while (int'(dump_idx) != target && n < 100) begin
         tick();
         n++;
      end
      chk(name, W'(dump_idx), W'(target));
   endtask

   task automatic wait_done(input int limit, input string name, output int cycles);
      cycles = 0;
      while (dump_busy && cycles < limit) begin
         tick();
         cycles++;
      end
      chk(name, W'(dump_busy), '0);
   endtask

   task automatic check_beats(input string name);
      chk({name, "_count"}, W'(beat_q.size()), W'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
         chk($sformatf("%s_beat%0d", name, i), beat_q[i], exp_q[i]);
      end
   endtask

   initial begin
      int cyc;

      // Reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk("rst_valid", W'(dump_valid), '0);
      chk("rst_busy", W'(dump_busy), '0);
      chk("rst_idx", W'(dump_idx), '0);
      chk("rst_data", dump_data, '0);

      // Write then read through the array
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      tick();
      we = 1'b0;
      set_ra(5, 0);
      #1;
      chk("r5_read", rd[31:0], 32'hDEADBEEF);
      chk("r0_read", rd[63:32], 32'h0);

      // Same-cycle bypass, then a write to R0 that must vanish
      we = 1'b1; wa = 5'd7; wd = 32'h1234;
      set_ra(7, 5);
      #1;
      chk("bypass_r7", rd[31:0], 32'h1234);
      chk("r5_port1", rd[63:32], 32'hDEADBEEF);
      tick();
      wa = 5'd0; wd = 32'hFFFF_FFFF;
      set_ra(0, 0);
      #1;
      chk("bypass_r0", rd[31:0], 32'h0);
      tick();
      we = 1'b0;
      set_ra(0, 7);
      #1;
      chk("r0_after_wr", rd[31:0], 32'h0);
      chk("r7_array", rd[63:32], 32'h1234);

      // HI/LO together with a GPR write
      hi_we = 1'b1; hi_wd = 32'hAAAA0000;
      lo_we = 1'b1; lo_wd = 32'h0000BBBB;
      we = 1'b1; wa = 5'd9; wd = 32'h55;
      #1;
      chk("hi_no_bypass", hi, 32'h0);
      tick();
      hi_we = 1'b0; lo_we = 1'b0; we = 1'b0;
      set_ra(9, 9);
      #1;
      chk("hi_wr", hi, 32'hAAAA0000);
      chk("lo_wr", lo, 32'h0000BBBB);
      chk("r9_wr", rd[31:0], 32'h55);
      reset = 1'b1;
      we = 1'b1; wa = 5'd11; wd = 32'hBAD;
      tick();
      reset = 1'b0; we = 1'b0;
      set_ra(9, 11);
      #1;
      chk("hi_rst", hi, 32'h0);
      chk("lo_rst", lo, 32'h0);
      chk("r9_rst", rd[31:0], 32'h0);
      chk("r11_dropped", rd[63:32], 32'h0);

      // Load Rn = n*0x10 and dump with ready held high
      for (int n = 1; n < D; n++) begin
         we = 1'b1; wa = AW'(n); wd = W'(n * 16);
         tick();
      end
      we = 1'b0;
      exp_q.delete();
      for (int n = 0; n < D; n++) exp_q.push_back(W'(n * 16));
      beat_q.delete();
      dump_ready = 1'b1;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      #1;
      chk("full_first_valid", W'(dump_valid), 32'h1);
      wait_done(100, "full_done", cyc);
      chk("full_cycles", W'(cyc), W'(D));
      check_beats("full");

      // Back-pressure at idx 3 with a write to R3 while stalled
      exp_q[3] = 32'h77;
      beat_q.delete();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      wait_idx(3, "bp_reach3");
      dump_ready = 1'b0;
      we = 1'b1; wa = 5'd3; wd = 32'h77;
      dump_start = 1'b1;
      #1;
      chk("bp_data_bypass", dump_data, 32'h77);
      tick();
      we = 1'b0; dump_start = 1'b0;
      #1;
      chk("bp_idx_hold", W'(dump_idx), 32'd3);
      chk("bp_data_array", dump_data, 32'h77);
      tick();
      tick();
      tick();
      chk("bp_idx_hold4", W'(dump_idx), 32'd3);
      dump_ready = 1'b1;
      tick();
      chk("bp_resume", W'(dump_idx), 32'd4);
      wait_done(100, "bp_done", cyc);
      tick();
      chk("bp_no_restart", W'(dump_valid), '0);
      check_beats("bp");

      // Reset mid-dump at idx 10, then a fresh dump of zeros
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      wait_idx(10, "rst_reach10");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_valid", W'(dump_valid), '0);
      chk("abort_busy", W'(dump_busy), '0);
      for (int a = 0; a < D; a++) begin
         set_ra(a, D - 1 - a);
         #1;
         chk($sformatf("zero_r%0d", a), rd[31:0], '0);
      end
      exp_q.delete();
      for (int n = 0; n < D; n++) exp_q.push_back('0);
      beat_q.delete();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      wait_done(100, "zero_done", cyc);
      check_beats("zero");
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
